// File: rtl/palette_lut_fader.sv
// Writable colour palette with a 2-stage read pipeline, a transparency flag
// and a global fade engine that scales every channel by a shared level.
module palette_lut_fader #(
    parameter int unsigned IDX_W         = 4,
    parameter int unsigned COLOR_W       = 4,
    parameter int unsigned TRANSP_IDX    = 0,
    parameter int unsigned FADE_STEP_CYC = 4
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic                 pix_valid,
    input  logic [IDX_W-1:0]     index,
    input  logic                 wr_en,
    input  logic [IDX_W-1:0]     wr_addr,
    input  logic [3*COLOR_W-1:0] wr_rgb,
    input  logic                 fade_start,
    input  logic                 fade_dir,
    output logic [COLOR_W-1:0]   red,
    output logic [COLOR_W-1:0]   green,
    output logic [COLOR_W-1:0]   blue,
    output logic                 out_valid,
    output logic                 out_transp,
    output logic                 fade_busy,
    output logic                 fade_done
);

    localparam int unsigned DEPTH   = 2 ** IDX_W;
    localparam int unsigned ENT_W   = 3 * COLOR_W;
    localparam int unsigned LVL_W   = COLOR_W + 1;
    localparam int unsigned PROD_W  = 2 * COLOR_W + 1;
    localparam int unsigned CNT_W   = (FADE_STEP_CYC > 1) ? $clog2(FADE_STEP_CYC) : 1;
    localparam int unsigned GREY_SH = COLOR_W - IDX_W;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FADE_STEP_CYC - 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(1) << COLOR_W;
    localparam logic [IDX_W-1:0] T_IDX    = IDX_W'(TRANSP_IDX);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_FADING = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    // Full-width product so nothing is lost before the shift.
    function automatic logic [COLOR_W-1:0] scale(input logic [COLOR_W-1:0] c,
                                                 input logic [LVL_W-1:0]   lvl);
        logic [PROD_W-1:0] p;
        p = PROD_W'(c) * PROD_W'(lvl);
        return COLOR_W'(p >> COLOR_W);
    endfunction

    logic [ENT_W-1:0]   mem_q [DEPTH];
    logic [ENT_W-1:0]   ent_s1_q;
    logic               transp_s1_q;
    logic               valid_s1_q;
    logic [LVL_W-1:0]   level_s1_q;

    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic               dir_q, dir_d;
    logic [LVL_W-1:0]   target_c;

    // Palette storage: grey ramp on reset, read-first single write port.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {3{COLOR_W'(i) << GREY_SH}};
            end
        end else if (wr_en) begin
            mem_q[wr_addr] <= wr_rgb;
        end
    end

    // Stage 1: capture entry, transparency match, valid and current level.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            ent_s1_q    <= '0;
            transp_s1_q <= 1'b0;
            valid_s1_q  <= 1'b0;
            level_s1_q  <= LVL_FULL;
        end else begin
            ent_s1_q    <= mem_q[index];
            transp_s1_q <= (index == T_IDX);
            valid_s1_q  <= pix_valid;
            level_s1_q  <= level_q;
        end
    end

    // Stage 2: scaled channels, held while no valid pixel arrives.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            red        <= '0;
            green      <= '0;
            blue       <= '0;
            out_transp <= 1'b0;
            out_valid  <= 1'b0;
        end else begin
            out_valid <= valid_s1_q;
            if (valid_s1_q) begin
                red        <= scale(ent_s1_q[2*COLOR_W +: COLOR_W], level_s1_q);
                green      <= scale(ent_s1_q[COLOR_W   +: COLOR_W], level_s1_q);
                blue       <= scale(ent_s1_q[0         +: COLOR_W], level_s1_q);
                out_transp <= transp_s1_q;
            end
        end
    end

    // Fade engine state register; busy/done are registered decodes of the next state.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            level_q   <= LVL_FULL;
            dir_q     <= 1'b0;
            fade_busy <= 1'b0;
            fade_done <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            dir_q     <= dir_d;
            fade_busy <= (state_d != ST_IDLE);
            fade_done <= (state_d == ST_DONE);
        end
    end

    // Fade next-state: step the level every FADE_STEP_CYC cycles until the target.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        level_d  = level_q;
        dir_d    = dir_q;
        target_c = dir_q ? LVL_FULL : '0;
        case (state_q)
            ST_IDLE: begin
                if (fade_start) begin
                    dir_d   = fade_dir;
                    cnt_d   = '0;
                    state_d = ST_FADING;
                end
            end
            ST_FADING: begin
                if (level_q == target_c) begin
                    state_d = ST_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    level_d = dir_q ? level_q + LVL_W'(1) : level_q - LVL_W'(1);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule
